ififo_skew: RTL and testbench

Input-side FIFO for the systolic MAC array, the counterpart of the column-write output FIFO. A whole row vector is written in one cycle. Each lane is then read out with a diagonal skew: lane i pops i cycles after lane 0. The skewed data enters the array's west edge directly, so the array needs no external skew registers. The block sits between the activation SRAM read path and the array's west inputs.

---
 rtl/ififo_skew.sv | 112 +++++++++++
 tb/tb_ififo_skew.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ififo_skew.sv
// rtl/ififo_skew.sv - row-wide input FIFO with diagonally skewed per-lane read-out
module ififo_skew #(
    parameter int row   = 8,
    parameter int bw    = 4,
    parameter int depth = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [row*bw-1:0]   in,
    input  logic                wr,
    input  logic                rd,
    output logic [row*bw-1:0]   out,
    output logic [row-1:0]      out_valid,
    output logic                o_full,
    output logic                o_ready,
    output logic                o_valid
);

    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;
    localparam logic [cw-1:0] full_cnt = cw'(depth);

    // Every lane is written in lockstep, so one write pointer serves all lanes.
    logic [aw-1:0] wptr;
    logic          wr_acc;
    logic          rd_acc;
    logic [row-1:0] tok;
    logic          lane0_nonempty;
    logic          last_full;

    // Flags come straight from registered counts: no same-cycle bypass.
    assign o_full  = last_full;
    assign o_ready = !last_full;
    assign o_valid = lane0_nonempty;
    assign wr_acc  = wr && !last_full;
    assign rd_acc  = rd && lane0_nonempty;

    // Shared write pointer advances on every accepted row write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
        end else if (wr_acc) begin
            wptr <= wptr + 1'b1;
        end
    end

    for (genvar i = 0; i < row; i++) begin : g_lane
        logic [bw-1:0] mem [depth];
        logic [aw-1:0] rptr;
        logic [cw-1:0] count;
        logic [bw-1:0] dout;
        logic          dval;

        // Skew pipe: lane 0 pops on the accepted rd itself, lane i one cycle after lane i-1.
        if (i == 0) begin : g_tok0
            assign tok[0] = rd_acc;
        end else begin : g_tokn
            logic tok_q;
            // One-cycle delay of the previous lane's pop token.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    tok_q <= 1'b0;
                end else begin
                    tok_q <= tok[i-1];
                end
            end
            assign tok[i] = tok_q;
        end

        // Lane storage; contents are don't-care after reset so it carries no reset.
        always_ff @(posedge clk) begin
            if (wr_acc) begin
                mem[wptr] <= in[i*bw +: bw];
            end
        end

        // Pop side and occupancy; push and pop together leave the count unchanged.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rptr  <= '0;
                count <= '0;
                dout  <= '0;
                dval  <= 1'b0;
            end else begin
                if (tok[i]) begin
                    dout <= mem[rptr];
                    rptr <= rptr + 1'b1;
                    dval <= 1'b1;
                end else begin
                    dval <= 1'b0;
                end
                case ({wr_acc, tok[i]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        assign out[i*bw +: bw] = dout;
        assign out_valid[i]    = dval;

        // Lane 0 is always the emptiest and the last lane the fullest.
        if (i == 0) begin : g_first
            assign lane0_nonempty = (count != '0);
        end
        if (i == row - 1) begin : g_last
            assign last_full = (count == full_cnt);
        end
    end

endmodule

// File: tb/tb_ififo_skew.sv
// tb/tb_ififo_skew.sv - self-checking bench for ififo_skew
module tb_ififo_skew;

    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 64;
    localparam int W     = ROW * BW;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [W-1:0]   in = '0;
    logic           wr = 1'b0;
    logic           rd = 1'b0;
    logic [W-1:0]   out;
    logic [ROW-1:0] out_valid;
    logic           o_full;
    logic           o_ready;
    logic           o_valid;

    ififo_skew #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .wr        (wr),
        .rd        (rd),
        .out       (out),
        .out_valid (out_valid),
        .o_full    (o_full),
        .o_ready   (o_ready),
        .o_valid   (o_valid)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model: rows not yet popped by lane 0, entries held by the last lane,
    // and per-lane scoreboards of (value, edge number) expected at the output.
    logic [W-1:0]  mq [$];
    int            nlast = 0;
    logic [BW-1:0] expv [ROW][$];
    int            expt [ROW][$];
    logic [BW-1:0] lastv [ROW];

    typedef struct {
        logic           w;
        logic           r;
        logic [W-1:0]   d;
        logic           ov;
        logic [ROW-1:0] ovv;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] lane_of(input logic [W-1:0] v, input int i);
        return v[i*BW +: BW];
    endfunction

    task automatic model_clear();
        mq.delete();
        nlast = 0;
        for (int i = 0; i < ROW; i++) begin
            expv[i].delete();
            expt[i].delete();
            lastv[i] = '0;
        end
    endtask

    // One clock: drive inputs, update the model at the edge, compare 1 time unit later.
    task automatic step(input logic w, input logic [W-1:0] d, input logic r);
        logic         acc_w;
        logic         acc_r;
        logic [W-1:0] v;
        wr = w;
        in = d;
        rd = r;
        acc_w = w && (nlast != DEPTH);
        acc_r = r && (mq.size() != 0);
        @(posedge clk);
        cyc++;
        if (acc_r) begin
            v = mq.pop_front();
            for (int i = 0; i < ROW; i++) begin
                expv[i].push_back(lane_of(v, i));
                expt[i].push_back(cyc + i);
            end
        end
        if (acc_w) begin
            mq.push_back(d);
            nlast++;
        end
        #1;
        wr = 1'b0;
        rd = 1'b0;
        for (int i = 0; i < ROW; i++) begin
            if (expt[i].size() != 0 && expt[i][0] == cyc) begin
                chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'd1);
                lastv[i] = expv[i].pop_front();
                void'(expt[i].pop_front());
                if (i == ROW - 1) nlast--;
            end else begin
                chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'd0);
            end
            chk($sformatf("out_lane%0d", i), 64'(lane_of(out, i)), 64'(lastv[i]));
        end
        chk("o_valid", 64'(o_valid), 64'(mq.size() != 0));
        chk("o_full",  64'(o_full),  64'(nlast == DEPTH));
        chk("o_ready", 64'(o_ready), 64'(nlast != DEPTH));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] v;
        model_clear();

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out",       64'(out),       64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_o_full",    64'(o_full),    64'd0);
        chk("rst_o_ready",   64'(o_ready),   64'd1);
        chk("rst_o_valid",   64'(o_valid),   64'd0);
        reset = 1'b0;
        idle(2);

        // rd on empty FIFO is dropped: no out_valid ever rises
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        idle(ROW + 1);

        // Single vector, lane i = i+1, one wave; table of per-cycle expectations
        tbl[0] = '{w: 1'b1, r: 1'b0, d: 32'h8765_4321, ov: 1'b1, ovv: 8'h00};
        tbl[1] = '{w: 1'b0, r: 1'b1, d: '0, ov: 1'b0, ovv: 8'h01};
        for (int k = 2; k < 9; k++) begin
            tbl[k] = '{w: 1'b0, r: 1'b0, d: '0, ov: 1'b0, ovv: 8'(1 << (k - 1))};
        end
        tbl[9] = '{w: 1'b0, r: 1'b0, d: '0, ov: 1'b0, ovv: 8'h00};
        for (int k = 0; k < 10; k++) begin
            step(tbl[k].w, tbl[k].d, tbl[k].r);
            chk($sformatf("tbl%0d_o_valid", k),   64'(o_valid),   64'(tbl[k].ov));
            chk($sformatf("tbl%0d_out_valid", k), 64'(out_valid), 64'(tbl[k].ovv));
        end

        // Three rows then three back-to-back waves
        step(1'b1, {ROW{4'h1}}, 1'b0);
        step(1'b1, {ROW{4'h2}}, 1'b0);
        step(1'b1, {ROW{4'h3}}, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        idle(ROW + 2);

        // Fill to full, attempt an overflow write, then drain in order
        for (int k = 0; k < DEPTH; k++) step(1'b1, W'($urandom), 1'b0);
        chk("fill_o_full",  64'(o_full),  64'd1);
        chk("fill_o_ready", 64'(o_ready), 64'd0);
        step(1'b1, {ROW{4'hF}} ^ W'(32'h1234_5678), 1'b0);
        for (int k = 0; k < DEPTH; k++) step(1'b0, '0, 1'b1);
        idle(ROW + 2);

        // Second pass to exercise pointer wrap
        for (int k = 0; k < DEPTH; k++) step(1'b1, W'($urandom), 1'b0);
        for (int k = 0; k < DEPTH; k++) step(1'b0, '0, 1'b1);
        idle(ROW + 2);

        // Random mixed traffic with simultaneous push/pop and near-full pressure
        for (int k = 0; k < 300; k++) begin
            v = W'($urandom);
            step(1'(($urandom_range(0, 3)) != 0), v, 1'($urandom_range(0, 1)));
        end
        idle(ROW + 2);

        // Reset in the middle of a wave
        model_clear();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, W'(32'hAAAA_AAAA), 1'b0);
        step(1'b1, W'(32'h5555_5555), 1'b0);
        step(1'b0, '0, 1'b1);
        idle(2);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_out",       64'(out),       64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_o_valid",   64'(o_valid),   64'd0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(ROW + 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
